// File: rtl/axi_ram_slave_if.sv
// AXI4 channel bundle between an upstream master/interconnect and the axi_ram_slave RAM endpoint.
interface axi_ram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 slave in front of a word-addressed RAM; independent write and read FSMs,
// FIXED/INCR/WRAP bursts, narrow transfers and byte strobes.
module axi_ram_slave #(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic           clk,
    input  logic           rst,
    axi_ram_slave_if.slave axi
);
    localparam int STRB_LOG2 = $clog2(AXI_STRB_WIDTH);
    localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01,
                              BURST_WRAP  = 2'b10, BURST_RSVD = 2'b11} burst_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step, mask, nxt;
        step = ONE << size;
        mask = ((ADDR_WIDTH'(len) + ONE) << size) - ONE;
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_WRAP:  nxt = (addr & ~mask) | ((addr + step) & mask);
            default:     nxt = (addr & ~(step - ONE)) + step;  // INCR and reserved
        endcase
        return nxt;
    endfunction

    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
        return (burst == BURST_RSVD) || (size > 3'(STRB_LOG2)) || bad_wrap;
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Outputs stay low in every cycle that follows a reset edge.
    logic out_en;

    always_ff @(posedge clk) begin
        // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
        if (!rst) out_en <= 1'b0;
        else      out_en <= 1'b1;
    end

    // ---------------- write path ----------------
    w_state_e w_state, w_state_nxt;
    logic [AXI_ID_WIDTH-1:0] w_id;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [7:0]              w_len, w_cnt;
    logic [2:0]              w_size;
    logic [1:0]              w_burst;
    logic                    w_err;
    logic aw_ready, w_ready, b_valid;
    logic aw_hs, w_hs, w_last_beat, mem_we;
    logic [MEM_WORDS_LOG2-1:0] w_word;

    assign aw_hs       = axi.awvalid && aw_ready;
    assign w_hs        = axi.wvalid && w_ready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_word      = w_addr[MEM_WORDS_LOG2+STRB_LOG2-1:STRB_LOG2];
    assign mem_we      = w_hs && !w_err && (axi.wlast == w_last_beat);

    always_ff @(posedge clk) begin
        if (!rst) w_state <= W_IDLE;
        else      w_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves the target unassigned (no latch).
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (b_valid && axi.bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        if (out_en) begin
            case (w_state)
                W_IDLE:  aw_ready = 1'b1;
                W_DATA:  w_ready  = 1'b1;
                W_RESP:  b_valid  = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= axi.awid;
            w_addr  <= axi.awaddr;
            w_len   <= axi.awlen;
            w_size  <= axi.awsize;
            w_burst <= axi.awburst;
            w_cnt   <= '0;
            w_err   <= burst_err(axi.awlen, axi.awsize, axi.awburst);
        end else if (w_hs) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            if (axi.wlast != w_last_beat) w_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch so it can map onto RAM; contents survive reset.
        if (mem_we) begin
            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
                if (axi.wstrb[b]) mem[w_word][b*8 +: 8] <= axi.wdata[b*8 +: 8];
            end
        end
    end

    assign axi.awready = aw_ready;
    assign axi.wready  = w_ready;
    assign axi.bvalid  = b_valid;
    assign axi.bid     = w_id;
    assign axi.bresp   = w_err ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read path ----------------
    r_state_e r_state, r_state_nxt;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0]     r_addr, rd_addr;
    logic [7:0]                r_len, r_cnt;
    logic [2:0]                r_size;
    logic [1:0]                r_burst;
    logic                      r_err, rd_err;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic ar_ready, r_valid;
    logic ar_hs, r_hs, r_last_beat, r_load;
    logic [MEM_WORDS_LOG2-1:0] rd_word;

    assign ar_hs       = axi.arvalid && ar_ready;
    assign r_hs        = r_valid && axi.rready;
    assign r_last_beat = (r_cnt == r_len);
    // The RAM is read one cycle ahead: on AR accept for beat 0, on each non-last R accept after.
    assign r_load  = ar_hs || (r_hs && !r_last_beat);
    assign rd_addr = ar_hs ? axi.araddr : next_addr(r_addr, r_len, r_size, r_burst);
    assign rd_err  = ar_hs ? burst_err(axi.arlen, axi.arsize, axi.arburst) : r_err;
    assign rd_word = rd_addr[MEM_WORDS_LOG2+STRB_LOG2-1:STRB_LOG2];

    always_ff @(posedge clk) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        if (out_en) begin
            ar_ready = (r_state == R_IDLE);
            r_valid  = (r_state == R_DATA);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (ar_hs) begin
                r_id    <= axi.arid;
                r_len   <= axi.arlen;
                r_size  <= axi.arsize;
                r_burst <= axi.arburst;
                r_cnt   <= '0;
                r_err   <= rd_err;
            end else if (r_load) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_load) begin
                r_addr  <= rd_addr;
                rdata_q <= rd_err ? '0 : mem[rd_word];
            end
        end
    end

    assign axi.arready = ar_ready;
    assign axi.rvalid  = r_valid;
    assign axi.rid     = r_id;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = r_err ? RESP_SLVERR : RESP_OKAY;
    assign axi.rlast   = r_valid && r_last_beat;

    logic unused_ok;
    assign unused_ok = ^{axi.awlock, axi.awcache, axi.awprot,
                         axi.arlock, axi.arcache, axi.arprot};
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: bursts, strobes, error responses and mid-burst reset.
module tb_axi_ram_slave;
    localparam int TMO = 50;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rexp [16];

    axi_ram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8)) axi ();

    axi_ram_slave #(
        .ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_STRB_WIDTH(4),
        .AXI_ID_WIDTH(8), .MEM_WORDS_LOG2(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .axi (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len;
        axi.awsize = size; axi.awburst = burst; axi.awvalid = 1'b1;
        while (axi.awready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        check("awready", 32'(axi.awready), 1);
        @(posedge clk); @(negedge clk);
        axi.awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        axi.arid = id; axi.araddr = addr; axi.arlen = len;
        axi.arsize = size; axi.arburst = burst; axi.arvalid = 1'b1;
        while (axi.arready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        check("arready", 32'(axi.arready), 1);
        @(posedge clk); @(negedge clk);
        axi.arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
        while (axi.wready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        check("wready", 32'(axi.wready), 1);
        @(posedge clk); @(negedge clk);
        axi.wvalid = 1'b0;
    endtask

    task automatic b_take(input logic [7:0] exp_id, input logic [1:0] exp_resp, input string tag);
        int n = 0;
        while (axi.bvalid !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        check({tag, ".bvalid"}, 32'(axi.bvalid), 1);
        check({tag, ".bid"}, 32'(axi.bid), 32'(exp_id));
        check({tag, ".bresp"}, 32'(axi.bresp), 32'(exp_resp));
        axi.bready = 1'b1;
        @(posedge clk); @(negedge clk);
        axi.bready = 1'b0;
        check({tag, ".bvalid_drop"}, 32'(axi.bvalid), 0);
    endtask

    task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                               input int last_at, input logic [1:0] exp_resp, input string tag);
        aw_send(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) w_beat(wbuf[i], strb, i == last_at);
        b_take(id, exp_resp, tag);
    endtask

    task automatic r_beat(input logic [31:0] exp_data, input logic [1:0] exp_resp, input logic exp_last,
                          input logic [7:0] exp_id, input bit stall, input string tag);
        int n = 0;
        while (axi.rvalid !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        check({tag, ".rvalid"}, 32'(axi.rvalid), 1);
        if (stall) begin
            check({tag, ".rdata_pre"}, axi.rdata, exp_data);
            axi.rready = 1'b0;
            @(posedge clk); @(negedge clk);
            check({tag, ".rvalid_hold"}, 32'(axi.rvalid), 1);
        end
        check({tag, ".rdata"}, axi.rdata, exp_data);
        check({tag, ".rresp"}, 32'(axi.rresp), 32'(exp_resp));
        check({tag, ".rlast"}, 32'(axi.rlast), 32'(exp_last));
        check({tag, ".rid"}, 32'(axi.rid), 32'(exp_id));
        axi.rready = 1'b1;
        @(posedge clk); @(negedge clk);
        axi.rready = 1'b0;
    endtask

    task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input bit stall,
                              input logic [1:0] exp_resp, input string tag);
        ar_send(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++)
            r_beat(rexp[i], exp_resp, i == int'(len), id, stall, $sformatf("%s[%0d]", tag, i));
        check({tag, ".rvalid_drop"}, 32'(axi.rvalid), 0);
    endtask

    initial begin
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awlock = 1'b0; axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.arlock = 1'b0; axi.arcache = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        rst = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.awready", 32'(axi.awready), 0);
        check("rst.arready", 32'(axi.arready), 0);
        check("rst.bvalid", 32'(axi.bvalid), 0);
        check("rst.rvalid", 32'(axi.rvalid), 0);
        check("rst.rdata", axi.rdata, 0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("post_rst.awready", 32'(axi.awready), 1);
        check("post_rst.arready", 32'(axi.arready), 1);

        // Single write then read
        wbuf[0] = 32'hDEADBEEF;
        write_burst(8'h5A, 32'h10, 8'd0, 3'd2, INCR, 4'hF, 0, OKAY, "single_wr");
        rexp[0] = 32'hDEADBEEF;
        read_burst(8'h3C, 32'h10, 8'd0, 3'd2, INCR, 1'b0, OKAY, "single_rd");

        // INCR burst, read back with rready stalls
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); rexp[i] = 32'(i + 1); end
        write_burst(8'h11, 32'h100, 8'd3, 3'd2, INCR, 4'hF, 3, OKAY, "incr_wr");
        read_burst(8'h12, 32'h100, 8'd3, 3'd2, INCR, 1'b1, OKAY, "incr_rd");

        // WRAP burst at 0x38 lands on 0x38,0x3C,0x30,0x34
        wbuf[0] = 32'hAAAA_000A; wbuf[1] = 32'hBBBB_000B;
        wbuf[2] = 32'hCCCC_000C; wbuf[3] = 32'hDDDD_000D;
        write_burst(8'h21, 32'h38, 8'd3, 3'd2, WRAP, 4'hF, 3, OKAY, "wrap_wr");
        rexp[0] = 32'hCCCC_000C; rexp[1] = 32'hDDDD_000D;
        rexp[2] = 32'hAAAA_000A; rexp[3] = 32'hBBBB_000B;
        read_burst(8'h22, 32'h30, 8'd3, 3'd2, INCR, 1'b0, OKAY, "wrap_rd");

        // Byte strobes over a zeroed word
        wbuf[0] = 32'h0;
        write_burst(8'h31, 32'h80, 8'd0, 3'd2, INCR, 4'hF, 0, OKAY, "strb_clr");
        wbuf[0] = 32'h11223344;
        write_burst(8'h32, 32'h80, 8'd0, 3'd2, INCR, 4'h5, 0, OKAY, "strb_wr");
        rexp[0] = 32'h00220044;
        read_burst(8'h33, 32'h80, 8'd0, 3'd2, INCR, 1'b0, OKAY, "strb_rd");

        // FIXED burst: last beat wins; FIXED read repeats the same word
        wbuf[0] = 32'd5; wbuf[1] = 32'd6; wbuf[2] = 32'd7;
        write_burst(8'h41, 32'h20, 8'd2, 3'd2, FIXED, 4'hF, 2, OKAY, "fixed_wr");
        rexp[0] = 32'd7; rexp[1] = 32'd7;
        read_burst(8'h42, 32'h20, 8'd1, 3'd2, FIXED, 1'b0, OKAY, "fixed_rd");

        // Reserved burst type: SLVERR and memory untouched
        wbuf[0] = 32'h12345678;
        write_burst(8'h51, 32'h40, 8'd0, 3'd2, INCR, 4'hF, 0, OKAY, "rsvd_pre");
        wbuf[0] = 32'hFFFFFFFF;
        write_burst(8'h52, 32'h40, 8'd0, 3'd2, RSVD, 4'hF, 0, SLVERR, "rsvd_wr");
        rexp[0] = 32'h12345678;
        read_burst(8'h53, 32'h40, 8'd0, 3'd2, INCR, 1'b0, OKAY, "rsvd_rd");

        // WRAP with illegal length on read: three zero beats with SLVERR
        for (int i = 0; i < 3; i++) rexp[i] = 32'h0;
        read_burst(8'h61, 32'h10, 8'd2, 3'd2, WRAP, 1'b0, SLVERR, "wrap_err_rd");

        // Oversized transfer on read
        rexp[0] = 32'h0;
        read_burst(8'h62, 32'h10, 8'd0, 3'd3, INCR, 1'b0, SLVERR, "size_err_rd");

        // Early wlast
        wbuf[0] = 32'h0BAD_0001; wbuf[1] = 32'h0BAD_0002;
        write_burst(8'h71, 32'h300, 8'd1, 3'd2, INCR, 4'hF, 0, SLVERR, "wlast_err_wr");

        // Error responses left earlier data intact
        rexp[0] = 32'hDEADBEEF;
        read_burst(8'h72, 32'h10, 8'd0, 3'd2, INCR, 1'b0, OKAY, "recheck_rd");

        // Reset in the middle of a read burst
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'h100 + 32'(i); rexp[i] = 32'h100 + 32'(i); end
        write_burst(8'h81, 32'h200, 8'd7, 3'd2, INCR, 4'hF, 7, OKAY, "mid_wr");
        ar_send(8'h82, 32'h200, 8'd7, 3'd2, INCR);
        r_beat(32'h100, OKAY, 1'b0, 8'h82, 1'b0, "mid_rd[0]");
        r_beat(32'h101, OKAY, 1'b0, 8'h82, 1'b0, "mid_rd[1]");
        check("mid_rd[2].rdata", axi.rdata, 32'h102);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("mid_rst.rvalid", 32'(axi.rvalid), 0);
        check("mid_rst.arready", 32'(axi.arready), 0);
        check("mid_rst.rdata", axi.rdata, 0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mid_rel.arready", 32'(axi.arready), 1);
        check("mid_rel.rvalid", 32'(axi.rvalid), 0);
        read_burst(8'h83, 32'h200, 8'd7, 3'd2, INCR, 1'b0, OKAY, "after_rst_rd");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
